envelope_scheduler: RTL and testbench

ENVELOPE_SCHEDULER -- requirements
Module: envelope_scheduler

---
 rtl/envelope_scheduler_if.sv | 25 ++
 rtl/envelope_scheduler.sv | 171 +++++++++++++++++
 tb/tb_envelope_scheduler.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/envelope_scheduler_if.sv
// Event handshake and envelope datapath bus of the envelope scheduler.
// master = scheduler side, slave = event source / envelope datapath side.
interface envelope_scheduler_if;
  logic        ev_valid;
  logic        ev_ready;
  logic [3:0]  ev_voice;
  logic        ev_on;
  logic [17:0] env_data_o;
  logic [17:0] env_data_i;
  logic [7:0]  env_out;
  logic        note_on;
  logic [3:0]  voice;
  logic        pass;
  logic        last;

  modport master (
    input  ev_valid, ev_voice, ev_on, env_data_i, env_out,
    output ev_ready, env_data_o, note_on, voice, pass, last
  );

  modport slave (
    output ev_valid, ev_voice, ev_on, env_data_i, env_out,
    input  ev_ready, env_data_o, note_on, voice, pass, last
  );
endinterface

// File: rtl/envelope_scheduler.sv
// Time-multiplexed envelope scheduler: walks all voices once per sample frame and mixes their amplitudes.
// Optional macro ENVELOPE_SCHEDULER_EVENT_FIFO_EN selects a 4-entry event FIFO instead of a single register.
module envelope_scheduler #(
  parameter int VOICES = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 sample_tick,
  envelope_scheduler_if.master bus,
  output logic [11:0]          mix_out,
  output logic                 mix_valid,
  output logic                 overrun
);

  typedef enum logic [1:0] {IDLE, RUN, TRAIL} state_t;

  localparam logic [4:0]  VOICE_COUNT = 5'(VOICES);
  localparam logic [3:0]  LAST_VOICE  = 4'(VOICES - 1);
  localparam logic [17:0] STATE_INIT  = {10'h300, 8'h00};

  state_t            state_q;
  state_t            state_d;
  logic [3:0]        voice_q;
  logic [11:0]       acc_q;
  logic [17:0]       env_state [VOICES];
  logic [VOICES-1:0] gate_q;
  logic              wb_en_q;
  logic [3:0]        wb_voice_q;

  logic              buf_empty;
  logic              buf_full;
  logic [3:0]        head_voice;
  logic              head_on;
  logic              push;
  logic              pop;

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (sample_tick) state_d = RUN;
      RUN:     if (voice_q == LAST_VOICE) state_d = TRAIL;
      TRAIL:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.pass = 1'b1;
    bus.last = 1'b0;
    unique case (state_q)
      RUN:     bus.pass = 1'b0;
      TRAIL:   bus.last = 1'b1;
      default: ;
    endcase
  end

  assign bus.voice      = voice_q;
  assign bus.env_data_o = env_state[voice_q];
  assign bus.note_on    = gate_q[voice_q];

  // The datapath result for a RUN cycle arrives one cycle later, so write-back trails the presented voice.
  always_ff @(posedge clock) begin
    if (reset) begin
      voice_q    <= 4'd0;
      acc_q      <= 12'd0;
      mix_out    <= 12'd0;
      mix_valid  <= 1'b0;
      overrun    <= 1'b0;
      wb_en_q    <= 1'b0;
      wb_voice_q <= 4'd0;
    end else begin
      mix_valid  <= 1'b0;
      wb_en_q    <= (state_q == RUN);
      wb_voice_q <= voice_q;
      unique case (state_q)
        IDLE: begin
          if (sample_tick) begin
            voice_q <= 4'd0;
            acc_q   <= 12'd0;
          end
        end
        RUN: begin
          acc_q   <= acc_q + {4'h0, bus.env_out};
          voice_q <= (voice_q == LAST_VOICE) ? 4'd0 : voice_q + 4'd1;
          if (sample_tick) overrun <= 1'b1;
        end
        TRAIL: begin
          mix_out   <= acc_q;
          mix_valid <= 1'b1;
          if (sample_tick) overrun <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < VOICES; i++) env_state[i] <= STATE_INIT;
      gate_q <= '0;
    end else begin
      if (wb_en_q) env_state[wb_voice_q] <= bus.env_data_i;
      if (pop)     gate_q[head_voice]    <= head_on;
    end
  end

  // Out-of-range voices are accepted but never enter the buffer.
  assign push         = bus.ev_valid && bus.ev_ready && ({1'b0, bus.ev_voice} < VOICE_COUNT);
  assign pop          = (state_q == IDLE) && !sample_tick && !buf_empty;
  assign bus.ev_ready = !buf_full;

`ifdef ENVELOPE_SCHEDULER_EVENT_FIFO_EN
  logic [4:0] fifo_mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= {bus.ev_voice, bus.ev_on};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: ;
      endcase
    end
  end

  assign buf_empty             = (count == 3'd0);
  assign buf_full              = (count == 3'd4);
  assign {head_voice, head_on} = fifo_mem[rd_ptr];
`else
  logic       buf_valid_q;
  logic [3:0] buf_voice_q;
  logic       buf_on_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      buf_valid_q <= 1'b0;
      buf_voice_q <= 4'd0;
      buf_on_q    <= 1'b0;
    end else if (push) begin
      buf_valid_q <= 1'b1;
      buf_voice_q <= bus.ev_voice;
      buf_on_q    <= bus.ev_on;
    end else if (pop) begin
      buf_valid_q <= 1'b0;
    end
  end

  assign buf_empty  = !buf_valid_q;
  assign buf_full   = buf_valid_q;
  assign head_voice = buf_voice_q;
  assign head_on    = buf_on_q;
`endif

endmodule

// File: tb/tb_envelope_scheduler.sv
// Self-checking bench for envelope_scheduler: vector table for the first frame, hand-written frame sequences,
// and a scoreboard of expected mix results; honours ENVELOPE_SCHEDULER_EVENT_FIFO_EN.
module tb_envelope_scheduler;
  localparam int VOICES = 16;
`ifdef ENVELOPE_SCHEDULER_EVENT_FIFO_EN
  localparam int BUF_DEPTH = 4;
`else
  localparam int BUF_DEPTH = 1;
`endif

  typedef struct {
    logic        tick;
    logic        chk_voice;
    logic        chk_env;
    logic        exp_pass;
    logic        exp_last;
    logic [3:0]  exp_voice;
    logic        exp_note;
    logic [17:0] exp_env;
  } vec_t;

  typedef struct {
    int mix;
    int at;
  } sb_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        sample_tick;
  logic [11:0] mix_out;
  logic        mix_valid;
  logic        overrun;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  sb_t         sb_q[$];
  sb_t         sb_e;
  vec_t        vecs[25];
  logic [3:0]  ev_vs[5];
  logic        ev_os[5];

  envelope_scheduler_if bus();

  envelope_scheduler #(.VOICES(VOICES)) dut (
    .clock       (clock),
    .reset       (reset),
    .sample_tick (sample_tick),
    .bus         (bus),
    .mix_out     (mix_out),
    .mix_valid   (mix_valid),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Datapath model: amplitude is voice*10 plus the gate, and the stored state counts presentations.
  assign bus.env_out = 8'(int'(bus.voice) * 10 + int'(bus.note_on));
  always @(posedge clock) bus.env_data_i <= bus.env_data_o + 18'd1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, actual, actual, expected, expected, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (mix_valid) begin
      if (sb_q.size() == 0) begin
        checkOutput("mix_unexpected", 1, 0);
      end else begin
        sb_e = sb_q.pop_front();
        checkOutput("mix_out", int'(mix_out), sb_e.mix);
        checkOutput("mix_latency", cyc, sb_e.at);
      end
    end
  end

  task automatic step();
    @(negedge clock);
  endtask

  task automatic applyStimulus(input logic tick, input logic evv, input logic [3:0] evvoice, input logic evon);
    sample_tick  = tick;
    bus.ev_valid = evv;
    bus.ev_voice = evvoice;
    bus.ev_on    = evon;
  endtask

  task automatic pushFrame(input int gate_ones);
    sb_e.mix = 1200 + gate_ones;
    sb_e.at  = cyc + VOICES + 2;
    sb_q.push_back(sb_e);
  endtask

  function automatic vec_t mkv(input logic tick, input logic cv, input logic ce, input logic p,
                               input logic l, input int vo, input logic [17:0] e);
    vec_t r;
    r.tick      = tick;
    r.chk_voice = cv;
    r.chk_env   = ce;
    r.exp_pass  = p;
    r.exp_last  = l;
    r.exp_voice = 4'(vo);
    r.exp_note  = 1'b0;
    r.exp_env   = e;
    return r;
  endfunction

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      checkOutput("idle_pass", int'(bus.pass), 1);
      checkOutput("idle_last", int'(bus.last), 0);
      checkOutput("idle_voice", int'(bus.voice), 0);
      step();
    end
  endtask

  // One full frame from IDLE: optional event burst starting at RUN voice ev_at, optional stray tick.
  task automatic runFrame(input logic [15:0] gate, input logic [17:0] env, input int ev_at,
                          input int ev_n, input int tick2_at);
    checkOutput("frame_start_pass", int'(bus.pass), 1);
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
    pushFrame($countones(gate));
    step();
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
    for (int v = 0; v < VOICES; v++) begin
      checkOutput("run_voice", int'(bus.voice), v);
      checkOutput("run_pass", int'(bus.pass), 0);
      checkOutput("run_last", int'(bus.last), 0);
      checkOutput("run_note_on", int'(bus.note_on), int'(gate[v]));
      checkOutput("run_env_data", int'(bus.env_data_o), int'(env));
      if (ev_at >= 0 && v >= ev_at && v < ev_at + ev_n) begin
        int j = v - ev_at;
        checkOutput("ev_ready_burst", int'(bus.ev_ready), (j < BUF_DEPTH) ? 1 : 0);
        applyStimulus(1'b0, 1'b1, ev_vs[j], ev_os[j]);
      end
      if (v == tick2_at) sample_tick = 1'b1;
      step();
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
    end
    checkOutput("trail_pass", int'(bus.pass), 1);
    checkOutput("trail_last", int'(bus.last), 1);
    if (tick2_at >= 0) checkOutput("trail_overrun", int'(overrun), 1);
    step();
    checkOutput("post_pass", int'(bus.pass), 1);
    checkOutput("post_last", int'(bus.last), 0);
    checkOutput("post_voice", int'(bus.voice), 0);
  endtask

  initial begin
    for (int i = 0; i < 5; i++) vecs[i] = mkv(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 18'h30000);
    vecs[5] = mkv(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 18'h30000);
    for (int v = 0; v < VOICES; v++) vecs[6+v] = mkv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, v, 18'h30000);
    vecs[22] = mkv(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 18'h0);
    vecs[23] = mkv(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 18'h30001);
    vecs[24] = mkv(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 18'h30001);

    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
    repeat (3) step();
    reset = 1'b0;
    checkOutput("reset_mix_out", int'(mix_out), 0);
    checkOutput("reset_mix_valid", int'(mix_valid), 0);
    checkOutput("reset_overrun", int'(overrun), 0);

    // First frame after reset, straight from the vector table.
    for (int i = 0; i < 25; i++) begin
      checkOutput("vec_pass", int'(bus.pass), int'(vecs[i].exp_pass));
      checkOutput("vec_last", int'(bus.last), int'(vecs[i].exp_last));
      checkOutput("vec_ready", int'(bus.ev_ready), 1);
      if (vecs[i].chk_voice) begin
        checkOutput("vec_voice", int'(bus.voice), int'(vecs[i].exp_voice));
        checkOutput("vec_note_on", int'(bus.note_on), int'(vecs[i].exp_note));
      end
      if (vecs[i].chk_env) checkOutput("vec_env_data", int'(bus.env_data_o), int'(vecs[i].exp_env));
      applyStimulus(vecs[i].tick, 1'b0, 4'd0, 1'b0);
      if (vecs[i].tick) pushFrame(0);
      step();
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
    end

    // Note-on for voice 3 in IDLE; a note-off issued mid-frame must wait for the next IDLE.
    applyStimulus(1'b0, 1'b1, 4'd3, 1'b1);
    checkOutput("evA_ready", int'(bus.ev_ready), 1);
    step();
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
    checkOutput("evA_ready_held", int'(bus.ev_ready), (BUF_DEPTH > 1) ? 1 : 0);
    step();
    checkOutput("evA_ready_free", int'(bus.ev_ready), 1);
    idleCycles(2);
    ev_vs[0] = 4'd3; ev_os[0] = 1'b0;
    runFrame(16'h0008, 18'h30001, 1, 1, -1);
    idleCycles(3);

    checkOutput("pre_overrun", int'(overrun), 0);
    runFrame(16'h0000, 18'h30002, -1, 0, 4);
    idleCycles(20);
    checkOutput("overrun_sticky", int'(overrun), 1);

    ev_vs[0] = 4'd5; ev_os[0] = 1'b1;
    ev_vs[1] = 4'd6; ev_os[1] = 1'b1;
    ev_vs[2] = 4'd5; ev_os[2] = 1'b0;
    ev_vs[3] = 4'd7; ev_os[3] = 1'b1;
    ev_vs[4] = 4'd8; ev_os[4] = 1'b1;
    runFrame(16'h0000, 18'h30003, 2, 5, -1);
    idleCycles(6);
    runFrame((BUF_DEPTH > 1) ? 16'h00C0 : 16'h0020, 18'h30004, -1, 0, -1);
    idleCycles(2);

    // Reset in the middle of a frame: the pending mix result must never appear.
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
    pushFrame(0);
    step();
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
    for (int v = 0; v < 7; v++) begin
      checkOutput("abort_voice", int'(bus.voice), v);
      step();
    end
    checkOutput("abort_voice7", int'(bus.voice), 7);
    reset = 1'b1;
    sb_q.delete();
    step();
    reset = 1'b0;
    checkOutput("abort_pass", int'(bus.pass), 1);
    checkOutput("abort_last", int'(bus.last), 0);
    checkOutput("abort_voice_idle", int'(bus.voice), 0);
    checkOutput("abort_ready", int'(bus.ev_ready), 1);
    checkOutput("abort_overrun", int'(overrun), 0);
    checkOutput("abort_mix_out", int'(mix_out), 0);
    checkOutput("abort_mix_valid", int'(mix_valid), 0);
    checkOutput("abort_env_data", int'(bus.env_data_o), 32'h30000);
    idleCycles(20);
    runFrame(16'h0000, 18'h30000, -1, 0, -1);
    idleCycles(3);

    checkOutput("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
